// File: rtl/dcpu_mem_responder_pkg.sv
// Shared definitions for the DCPU-16 memory responder: boot-FSM states,
// default bus widths and the bus word type.
package dcpu_pkg;

    localparam int unsigned DCPU_AWIDTH = 16;
    localparam int unsigned DCPU_DWIDTH = 16;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    typedef logic [DCPU_DWIDTH-1:0] word_t;

endpackage

// File: rtl/dcpu_mem_responder_spram.sv
// Single-port synchronous word RAM with a registered read port; a write in
// the same cycle as a read wins and leaves the read register untouched.
module dcpu_spram #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned ALOG2  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ALOG2-1:0]  addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [0:(1<<ALOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dcpu_mem_responder.sv
// DCPU-16 word-bus memory responder: boots RAM from a host stream, then serves
// the core. Optional ld_csum output enabled by DCPU_MEM_LOAD_CSUM_EN.
module dcpu_mem_responder
    import dcpu_pkg::*;
#(
    parameter int unsigned AWIDTH     = DCPU_AWIDTH,
    parameter int unsigned DWIDTH     = DCPU_DWIDTH,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [AWIDTH-2:0] memaddr,
    input  logic [DWIDTH-1:0] wmemdata,
    output logic [DWIDTH-1:0] rmemdata,
    output logic              cpu_rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DWIDTH-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ovf,
    output logic              boot_done
`ifdef DCPU_MEM_LOAD_CSUM_EN
    ,
    output logic [DWIDTH-1:0] ld_csum
`endif
);

    state_t                  state, state_next;
    logic [DEPTH_LOG2-1:0]   ptr;
    logic                    xfer;
    logic                    ram_we, ram_re;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [DWIDTH-1:0]       ram_wdata;

    assign xfer      = (state == LOAD) && ld_valid && ld_ready;
    assign cpu_rst   = (state != RUN);
    assign boot_done = (state == RUN);

    // ld_ready is registered from the next state so it rises one cycle after rst drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            ptr      <= '0;
            ld_ready <= 1'b0;
            ld_ovf   <= 1'b0;
        end else begin
            state    <= state_next;
            ld_ready <= (state_next == LOAD);
            if (xfer) begin
                ptr <= ptr + DEPTH_LOG2'(1);
                if (ptr == '1) begin
                    ld_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = ptr;
        ram_wdata  = ld_data;
        case (state)
            LOAD: begin
                ram_we = xfer;
                if (xfer && ld_last) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = RUN;
            RUN: begin
                ram_we    = mem_we;
                ram_re    = mem_re;
                ram_addr  = memaddr[DEPTH_LOG2-1:0];
                ram_wdata = wmemdata;
            end
            default: state_next = LOAD;
        endcase
        if (rst) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // Upper core address bits alias onto the RAM and are deliberately dropped
    if (DEPTH_LOG2 < AWIDTH - 1) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^memaddr[AWIDTH-2:DEPTH_LOG2];
    end

`ifdef DCPU_MEM_LOAD_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_csum <= '0;
        end else if (xfer) begin
            ld_csum <= ld_csum + ld_data;
        end
    end
`endif

    dcpu_spram #(
        .DWIDTH (DWIDTH),
        .ALOG2  (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rmemdata)
    );

endmodule

// File: tb/tb_dcpu_mem_responder.sv
// Directed self-checking bench for dcpu_mem_responder (default depth and a
// 16-word instance sharing the same stimulus).
module tb_dcpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst, mem_re, mem_we, ld_valid, ld_last;
    logic [14:0] memaddr;
    logic [15:0] wmemdata, ld_data;

    logic [15:0] rmemdata, r4_rmemdata;
    logic        cpu_rst, ld_ready, ld_ovf, boot_done;
    logic        r4_cpu_rst, r4_ld_ready, r4_ld_ovf, r4_boot_done;
`ifdef DCPU_MEM_LOAD_CSUM_EN
    logic [15:0] ld_csum, r4_ld_csum;
`endif

    int unsigned checks = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    dcpu_mem_responder dut (
        .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we),
        .memaddr(memaddr), .wmemdata(wmemdata), .rmemdata(rmemdata),
        .cpu_rst(cpu_rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ovf(ld_ovf),
        .boot_done(boot_done)
`ifdef DCPU_MEM_LOAD_CSUM_EN
        , .ld_csum(ld_csum)
`endif
    );

    dcpu_mem_responder #(.DEPTH_LOG2(4)) dut4 (
        .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we),
        .memaddr(memaddr), .wmemdata(wmemdata), .rmemdata(r4_rmemdata),
        .cpu_rst(r4_cpu_rst), .ld_valid(ld_valid), .ld_ready(r4_ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ovf(r4_ld_ovf),
        .boot_done(r4_boot_done)
`ifdef DCPU_MEM_LOAD_CSUM_EN
        , .ld_csum(r4_ld_csum)
`endif
    );

    typedef struct {
        logic        re;
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_cpu_rst", 16'(cpu_rst), 16'd1);
        check("rst_ld_ready", 16'(ld_ready), 16'd0);
        check("rst_rmemdata", rmemdata, 16'h0000);
        check("rst_boot_done", 16'(boot_done), 16'd0);
        check("rst_ld_ovf", 16'(ld_ovf), 16'd0);
        rst = 1'b0;
        check("ld_ready_first_cycle", 16'(ld_ready), 16'd0);
        tick();
        check("ld_ready_after_rst", 16'(ld_ready), 16'd1);
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        check("send_ld_ready", 16'(ld_ready), 16'd1);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Finishes the boot after the last transfer: one RELEASE cycle, then RUN
    task automatic finish_boot(input string tag);
        check({tag, "_release_cpu_rst"}, 16'(cpu_rst), 16'd1);
        check({tag, "_release_ld_ready"}, 16'(ld_ready), 16'd0);
        tick();
        check({tag, "_run_cpu_rst"}, 16'(cpu_rst), 16'd0);
        check({tag, "_run_boot_done"}, 16'(boot_done), 16'd1);
    endtask

    task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string name);
        mem_re  = 1'b1;
        memaddr = a;
        tick();
        mem_re  = 1'b0;
        check(name, rmemdata, exp);
    endtask

    task automatic rd4(input logic [14:0] a, input logic [15:0] exp, input string name);
        mem_re  = 1'b1;
        memaddr = a;
        tick();
        mem_re  = 1'b0;
        check(name, r4_rmemdata, exp);
    endtask

    initial begin
        mem_re = 1'b0; mem_we = 1'b0; memaddr = '0; wmemdata = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

        //                re    we    addr      wdata     expected rmemdata
        vecs[0]  = '{1'b0, 1'b1, 15'h0010, 16'hBEEF, 16'h3333};
        vecs[1]  = '{1'b1, 1'b0, 15'h0010, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1'b1, 1'b0, 15'h1010, 16'h0000, 16'hBEEF};
        vecs[3]  = '{1'b1, 1'b1, 15'h0020, 16'h1234, 16'hBEEF};
        vecs[4]  = '{1'b0, 1'b0, 15'h0020, 16'h0000, 16'hBEEF};
        vecs[5]  = '{1'b1, 1'b0, 15'h0020, 16'h0000, 16'h1234};
        vecs[6]  = '{1'b0, 1'b1, 15'h7FFF, 16'hA5A5, 16'h1234};
        vecs[7]  = '{1'b1, 1'b0, 15'h0FFF, 16'h0000, 16'hA5A5};
        vecs[8]  = '{1'b1, 1'b0, 15'h0000, 16'h0000, 16'h1111};
        vecs[9]  = '{1'b0, 1'b1, 15'h0000, 16'h5555, 16'h1111};
        vecs[10] = '{1'b1, 1'b0, 15'h1000, 16'h0000, 16'h5555};
        vecs[11] = '{1'b1, 1'b0, 15'h0002, 16'h0000, 16'h3333};

        // Basic boot of a 3-word image
        do_reset();
        send(16'h7C01, 1'b0);
        send(16'h0030, 1'b0);
        send(16'h0000, 1'b1);
        finish_boot("t1");
        rd(15'h0000, 16'h7C01, "t1_ram0");
        rd(15'h0001, 16'h0030, "t1_ram1");
        rd(15'h0002, 16'h0000, "t1_ram2");

        // Loader stall with junk on ld_data/ld_last while invalid
        do_reset();
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        ld_data = 16'hDEAD;
        ld_last = 1'b1;
        repeat (5) tick();
        ld_last = 1'b0;
        check("t2_stall_ld_ready", 16'(ld_ready), 16'd1);
        check("t2_stall_cpu_rst", 16'(cpu_rst), 16'd1);
        send(16'h3333, 1'b1);
        finish_boot("t2");
        rd(15'h0000, 16'h1111, "t2_ram0");
        rd(15'h0001, 16'h2222, "t2_ram1");
        rd(15'h0002, 16'h3333, "t2_ram2");

        // Core bus vectors in RUN
        for (int i = 0; i < 12; i++) begin
            mem_re   = vecs[i].re;
            mem_we   = vecs[i].we;
            memaddr  = vecs[i].addr;
            wmemdata = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d_rmemdata", i), rmemdata, vecs[i].exp);
        end
        mem_re = 1'b0; mem_we = 1'b0;
        ld_valid = 1'b1; ld_data = 16'hDEAD;
        tick();
        ld_valid = 1'b0;
        check("run_ld_ready", 16'(ld_ready), 16'd0);
        check("run_ignores_loader", 16'(boot_done), 16'd1);

        // Reset mid-load, then reload from address 0
        do_reset();
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        rst = 1'b1;
        tick();
        check("t6_rst_cpu_rst", 16'(cpu_rst), 16'd1);
        check("t6_rst_ld_ready", 16'(ld_ready), 16'd0);
        check("t6_rst_ld_ovf", 16'(ld_ovf), 16'd0);
`ifdef DCPU_MEM_LOAD_CSUM_EN
        check("t6_rst_csum", ld_csum, 16'h0000);
`endif
        rst = 1'b0;
        tick();
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
`ifdef DCPU_MEM_LOAD_CSUM_EN
        check("t6_csum", ld_csum, 16'h0001);
`endif
        finish_boot("t6");
        rd(15'h0000, 16'hFFFF, "t6_ram0");
        rd(15'h0001, 16'h0002, "t6_ram1");
        rd(15'h0002, 16'h3333, "t6_ram2_kept");
`ifdef DCPU_MEM_LOAD_CSUM_EN
        check("t6_csum_frozen", ld_csum, 16'h0001);
`endif

        // 17-word stream into the 16-word instance wraps and flags overflow
        do_reset();
        for (int k = 0; k < 15; k++) send(16'(k), 1'b0);
        check("t5_ovf_before_max", 16'(r4_ld_ovf), 16'd0);
        send(16'd15, 1'b0);
        check("t5_ovf_at_max", 16'(r4_ld_ovf), 16'd1);
        send(16'd16, 1'b1);
        check("t5_ovf_default_depth", 16'(ld_ovf), 16'd0);
`ifdef DCPU_MEM_LOAD_CSUM_EN
        check("t5_csum", r4_ld_csum, 16'h0088);
`endif
        finish_boot("t5");
        check("t5_ovf_sticky", 16'(r4_ld_ovf), 16'd1);
        rd4(15'h0000, 16'd16, "t5_ram0");
        rd4(15'h0001, 16'd1, "t5_ram1");
        rd4(15'h000F, 16'd15, "t5_ram15");
        rd4(15'h0010, 16'd16, "t5_alias16");
        rst = 1'b1;
        tick();
        check("t5_ovf_cleared", 16'(r4_ld_ovf), 16'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
